// File: rtl/bit_sampler.sv
// Oversampling bit sampler for a UART-style receiver.
// Latency: the 2-flop synchroniser, then the decision is registered at
//   edge_cnt = M+1 and sample_valid pulses for the following cycle.
// Backpressure: none. It runs freely while dat_samp_en is high.
//
// Ports:
//   CLK, RST     - clock; asynchronous active-high reset
//   RX_IN        - raw serial line (asynchronous, idle high)
//   dat_samp_en  - enables counting and sampling (driven by the RX FSM)
//   prescale     - CLK cycles per bit; values below 4 are treated as 4
//   sampled_bit  - registered decision for the current bit
//   sample_valid - one-cycle pulse when sampled_bit is refreshed
//   edge_cnt     - oversample position within the current bit
//   bit_cnt      - completed bit periods since dat_samp_en rose (wraps)
//
// Optional feature: define MAJORITY_VOTE_EN for a 2-of-3 vote over the
// samples taken at M-1, M and M+1. Without it the sample at M is used alone.
module bit_sampler #(
    parameter int PRESC_W  = 6,
    parameter int BITCNT_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX_IN,
    input  logic                dat_samp_en,
    input  logic [PRESC_W-1:0]  prescale,
    output logic                sampled_bit,
    output logic                sample_valid,
    output logic [PRESC_W-1:0]  edge_cnt,
    output logic [BITCNT_W-1:0] bit_cnt
);

    localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(4);
    localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);

    // Synchroniser. Both flops reset to the idle line level.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // Effective prescale and sample positions. They are derived combinationally
    // from prescale, so a prescale change takes effect in the same cycle.
    logic [PRESC_W-1:0] p_eff;
    logic [PRESC_W-1:0] mid;
    logic [PRESC_W-1:0] last_pos;
    logic               wrap;
    logic               at_pre;   // edge_cnt == M-1
    logic               at_mid;   // edge_cnt == M
    logic               at_post;  // edge_cnt == M+1, decision cycle

    always_comb begin
        p_eff    = (prescale < P_MIN) ? P_MIN : prescale;
        mid      = p_eff >> 1;
        last_pos = p_eff - ONE;
        // ">=" rather than "==": if prescale shrinks below the current
        // position, the bit ends at once instead of running to the next wrap.
        wrap     = (edge_cnt >= last_pos);
        at_pre   = dat_samp_en && (edge_cnt == (mid - ONE));
        at_mid   = dat_samp_en && (edge_cnt == mid);
        at_post  = dat_samp_en && (edge_cnt == (mid + ONE));
    end

    // Edge and bit counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!dat_samp_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BITCNT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    // Sample capture and decision
    logic decision;

`ifdef MAJORITY_VOTE_EN
    logic s0;
    logic s1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (at_pre) s0 <= rx_s;
            if (at_mid) s1 <= rx_s;
        end
    end

    // The third sample is the live rx_s in the decision cycle. It is voted
    // directly, so no third register is needed.
    always_comb begin
        decision = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    end
`else
    logic s1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1 <= 1'b1;
        end else if (at_mid) begin
            s1 <= rx_s;
        end
    end

    // The decision still lands at M+1, so sample_valid timing is the same
    // with or without the vote.
    always_comb begin
        decision = s1;
    end
`endif

    // Output registers. sampled_bit holds its value between decisions.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= at_post;
            if (at_post) sampled_bit <= decision;
        end
    end

endmodule

// File: tb/tb_bit_sampler.sv
module tb_bit_sampler;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          dat_samp_en;
    logic [PW-1:0] prescale;
    logic          sampled_bit;
    logic          sample_valid;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;

    bit_sampler #(.PRESC_W(PW), .BITCNT_W(BW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .dat_samp_en  (dat_samp_en),
        .prescale     (prescale),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Expected sampled_bit for each pending sample_valid pulse
    bit exp_q[$];
    int pulse_cnt = 0;
    bit mon_exp;

    // Reference model. The position and bit count follow the stated rules.
    // line_s/line_m hold the RX_IN values from two cycles and one cycle ago.
    int m_pos, m_bits;
    bit m_sb, m_valid, m_s0, m_s1, line_s, line_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_bits = 0; m_sb = 1'b1; m_valid = 1'b0;
        m_s0 = 1'b1; m_s1 = 1'b1; line_s = 1'b1; line_m = 1'b1;
    endtask

    // Advance the model over one rising edge, using the inputs held before it.
    task automatic model_next(input bit en, input int presc, input bit rx);
        int p;
        int mid;
        bit dec;
        p   = (presc < 4) ? 4 : presc;
        mid = p / 2;
        m_valid = 1'b0;
        if (en) begin
            if (m_pos == mid - 1) m_s0 = line_s;
            if (m_pos == mid)     m_s1 = line_s;
            if (m_pos == mid + 1) begin
`ifdef MAJORITY_VOTE_EN
                dec = ((int'(m_s0) + int'(m_s1) + int'(line_s)) >= 2);
`else
                dec = m_s1;
`endif
                m_sb = dec;
                m_valid = 1'b1;
                chk("missed_pulse", exp_q.size(), 0);
                exp_q.push_back(dec);
            end
            if (m_pos >= p - 1) begin
                m_pos  = 0;
                m_bits = (m_bits + 1) % (1 << BW);
            end else begin
                m_pos++;
            end
        end else begin
            m_pos  = 0;
            m_bits = 0;
        end
        line_s = line_m;
        line_m = rx;
    endtask

    task automatic check_outputs();
        chk("edge_cnt", edge_cnt, m_pos);
        chk("bit_cnt", bit_cnt, m_bits);
        chk("sampled_bit", sampled_bit, m_sb);
        chk("sample_valid", sample_valid, m_valid);
    endtask

    // One cycle: compare the current outputs, then drive inputs for the next edge.
    task automatic step(input bit en, input int presc, input bit rx);
        @(negedge CLK);
        check_outputs();
        dat_samp_en = en;
        prescale    = PW'(presc);
        RX_IN       = rx;
        model_next(en, presc, rx);
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, then release it.
    task automatic do_reset();
        @(negedge CLK);
        check_outputs();
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        check_outputs();
        RST = 1'b0;
        model_next(dat_samp_en, int'(prescale), RX_IN);
    endtask

    // Monitor: pops the expected value whenever the DUT flags a sample
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sample_valid === 1'b1) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: actual sample_valid=1 expected none t=%0t", $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("pulse_sampled_bit", sampled_bit, mon_exp);
                end
            end
        end
    end

    initial begin
        bit rx_cur;
        bit en_cur;
        int pr_cur;
        int guard;

        RST = 1'b1; dat_samp_en = 1'b0; prescale = PW'(8); RX_IN = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        check_outputs();
        RST = 1'b0;
        model_next(1'b0, 8, 1'b1);

        // Steady 0 at prescale 8
        repeat (4) step(1'b0, 8, 1'b0);
        repeat (20) step(1'b1, 8, 1'b0);
        repeat (4) step(1'b0, 8, 1'b1);

        // Prescale below the minimum behaves as 4
        repeat (12) step(1'b1, 2, 1'($urandom_range(0, 1)));
        repeat (3) step(1'b0, 2, 1'b1);

        // One-cycle glitch reaching rx_s at edge_cnt = 8
        repeat (3) step(1'b0, 16, 1'b1);
        repeat (32) step(1'b1, 16, (m_pos == 6) ? 1'b0 : 1'b1);
        repeat (3) step(1'b0, 16, 1'b1);

        // Enable dropped at edge_cnt = 5
        guard = 0;
        do begin
            step(1'b1, 16, 1'b0);
            guard++;
        end while (m_pos != 5 && guard < 40);
        chk("reach_pos5", m_pos, 5);
        step(1'b0, 16, 1'b0);
        repeat (3) step(1'b0, 16, 1'b1);

        // Reset pulsed at edge_cnt = 9, enable kept high
        guard = 0;
        do begin
            step(1'b1, 16, 1'b0);
            guard++;
        end while (m_pos != 9 && guard < 40);
        chk("reach_pos9", m_pos, 9);
        do_reset();
        repeat (20) step(1'b1, 16, 1'b0);
        repeat (3) step(1'b0, 16, 1'b1);

        // 16 bit periods at prescale 32: bit_cnt wraps and exactly 16 samples
        step(1'b0, 32, 1'b1);
        pulse_cnt = 0;
        repeat (16 * 32) step(1'b1, 32, 1'($urandom_range(0, 1)));
        step(1'b0, 32, 1'b1);
        step(1'b0, 32, 1'b1);
        chk("pulses_16_bits", pulse_cnt, 16);

        // Randomised traffic
        rx_cur = 1'b1; en_cur = 1'b0; pr_cur = 8;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rx_cur = ~rx_cur;
            if ($urandom_range(0, 99) < 3) en_cur = ~en_cur;
            if (!en_cur && $urandom_range(0, 3) == 0) pr_cur = $urandom_range(0, 63);
            if (en_cur && $urandom_range(0, 299) == 0) pr_cur = $urandom_range(0, 63);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(en_cur, pr_cur, rx_cur);
            end
        end
        repeat (3) step(1'b0, pr_cur, 1'b1);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
